// File: rtl/prog_updown_counter.sv
// prog_updown_counter: up/down counter over 0..limit with load, prescaled enable,
// wrap-or-saturate bounds, registered terminal-count pulse and pin output enable.
module prog_updown_counter #(
  parameter int WIDTH    = 8,
  parameter bit SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             up_dn,
  input  logic [WIDTH-1:0] limit,
  input  logic [3:0]       prescale,
  input  logic             oe,
  output logic [WIDTH-1:0] count_out,
  output logic [WIDTH-1:0] count_oe,
  output logic             tc,
  output logic             at_bound
);
  logic [WIDTH-1:0] count_q, count_d, bound_val;
  logic [3:0]       pre_q, pre_d;
  logic             tc_q, tc_d, tick;
  assign at_bound  = up_dn ? (count_q >= limit) : (count_q == '0);
  assign tick      = en && (pre_q >= prescale);
  // value taken when a tick hits the bound; saturating up also clamps out-of-range counts
  assign bound_val = (up_dn ^ SATURATE) ? '0 : limit;
  assign count_out = oe ? count_q : '0;
  assign count_oe  = oe ? '1 : '0;
  assign tc        = tc_q;
  always_comb begin
    count_d = count_q;
    pre_d   = pre_q;
    tc_d    = 1'b0;
    if (load) begin
      count_d = load_val;
      pre_d   = '0;
    end else if (tick) begin
      pre_d   = '0;
      tc_d    = at_bound;
      count_d = at_bound ? bound_val : (up_dn ? count_q + WIDTH'(1) : count_q - WIDTH'(1));
    end else if (en) begin
      pre_d   = pre_q + 4'd1;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      pre_q   <= '0;
      tc_q    <= 1'b0;
    end else begin
      count_q <= count_d;
      pre_q   <= pre_d;
      tc_q    <= tc_d;
    end
  end
endmodule

// File: tb/tb_prog_updown_counter.sv
// tb_prog_updown_counter: wrap and saturate instances driven together, checked
// against a per-edge arithmetic reference model through an expectation queue.
module tb_prog_updown_counter;
  logic       clk = 1'b0, rst_n = 1'b0;
  logic       en = 1'b0, load = 1'b0, up_dn = 1'b1, oe = 1'b0;
  logic [7:0] load_val = '0, limit = '0;
  logic [3:0] prescale = '0;
  logic [7:0] co0, co1, coe0, coe1;
  logic       tc0, tc1, ab0, ab1;
  int checks = 0, errors = 0;
  typedef struct packed {
    logic [7:0] co0, co1, coe;
    logic       tc0, tc1, ab0, ab1;
  } exp_t;
  exp_t q[$];
  int   mc[2];
  int   mp;
  bit   mt[2];
  prog_updown_counter #(.WIDTH(8), .SATURATE(1'b0)) u_wrap (
    .clk(clk), .rst_n(rst_n), .en(en), .load(load), .load_val(load_val), .up_dn(up_dn),
    .limit(limit), .prescale(prescale), .oe(oe), .count_out(co0), .count_oe(coe0),
    .tc(tc0), .at_bound(ab0));
  prog_updown_counter #(.WIDTH(8), .SATURATE(1'b1)) u_sat (
    .clk(clk), .rst_n(rst_n), .en(en), .load(load), .load_val(load_val), .up_dn(up_dn),
    .limit(limit), .prescale(prescale), .oe(oe), .count_out(co1), .count_oe(coe1),
    .tc(tc1), .at_bound(ab1));
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [15:0] a, input logic [15:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask
  // reference: one enabled edge of the specified behaviour, s=0 wraps, s=1 saturates
  task automatic step(input bit e, input bit l, input int lv, input bit u, input int lim,
                      input int ps, input bit o);
    exp_t x;
    bit   hit;
    @(negedge clk);
    en = e; load = l; load_val = 8'(lv); up_dn = u; limit = 8'(lim); prescale = 4'(ps); oe = o;
    if (l) begin
      mp = 0;
      for (int s = 0; s < 2; s++) begin mc[s] = lv; mt[s] = 0; end
    end else if (e && mp >= ps) begin
      mp = 0;
      for (int s = 0; s < 2; s++) begin
        hit   = u ? (mc[s] >= lim) : (mc[s] == 0);
        mt[s] = hit;
        if (!hit) mc[s] = u ? mc[s] + 1 : mc[s] - 1;
        else if (u) mc[s] = (s == 1) ? lim : 0;
        else mc[s] = (s == 1) ? 0 : lim;
      end
    end else begin
      if (e) mp++;
      mt[0] = 0; mt[1] = 0;
    end
    x.co0 = o ? 8'(mc[0]) : 8'h00;
    x.co1 = o ? 8'(mc[1]) : 8'h00;
    x.coe = o ? 8'hFF : 8'h00;
    x.tc0 = mt[0];
    x.tc1 = mt[1];
    x.ab0 = u ? (mc[0] >= lim) : (mc[0] == 0);
    x.ab1 = u ? (mc[1] >= lim) : (mc[1] == 0);
    q.push_back(x);
  endtask
  task automatic async_reset();
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("rst_count_wrap", co0, 0);
    chk("rst_count_sat", co1, 0);
    chk("rst_tc_wrap", tc0, 0);
    chk("rst_tc_sat", tc1, 0);
    mp = 0;
    for (int s = 0; s < 2; s++) begin mc[s] = 0; mt[s] = 0; end
    rst_n = 1'b1;
  endtask
  always @(posedge clk) begin
    exp_t x;
    #1;
    if (q.size() > 0) begin
      x = q.pop_front();
      chk("count_wrap", co0, x.co0);
      chk("count_sat", co1, x.co1);
      chk("oe_wrap", coe0, x.coe);
      chk("oe_sat", coe1, x.coe);
      chk("tc_wrap", tc0, x.tc0);
      chk("tc_sat", tc1, x.tc1);
      chk("bound_wrap", ab0, x.ab0);
      chk("bound_sat", ab1, x.ab1);
    end
  end
  initial begin
    bit u, l, e, o;
    int lim, ps, lv;
    mp = 0; mc[0] = 0; mc[1] = 0; mt[0] = 0; mt[1] = 0;
    #1;
    chk("reset_count", co0, 0);
    chk("reset_oe", coe0, 0);
    chk("reset_tc", tc1, 0);
    #2 rst_n = 1'b1;
    repeat (6) step(1, 0, 0, 1, 5, 0, 1);
    step(1, 0, 0, 1, 5, 0, 0);
    repeat (10) step(1, 0, 0, 1, 200, 3, 1);
    repeat (2) step(0, 0, 0, 1, 200, 3, 1);
    repeat (6) step(1, 0, 0, 1, 200, 3, 1);
    step(0, 1, 8, 1, 10, 0, 1);
    repeat (5) step(1, 0, 0, 1, 10, 0, 1);
    step(0, 1, 2, 0, 10, 0, 1);
    repeat (4) step(1, 0, 0, 0, 10, 0, 1);
    step(0, 1, 1, 0, 200, 0, 1);
    repeat (3) step(1, 0, 0, 0, 200, 0, 1);
    step(1, 1, 240, 1, 16, 0, 1);
    step(1, 0, 0, 1, 16, 0, 1);
    repeat (3) step(1, 0, 0, 1, 0, 0, 1);
    step(0, 1, 51, 1, 255, 5, 1);
    repeat (2) step(1, 0, 0, 1, 255, 5, 1);
    async_reset();
    repeat (8) step(1, 0, 0, 1, 255, 5, 1);
    u = 1; lim = 6; ps = 0;
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 9) == 0) u = 1'($urandom);
      if ($urandom_range(0, 19) == 0)
        lim = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 12));
      if ($urandom_range(0, 14) == 0)
        ps = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 3));
      l  = ($urandom_range(0, 11) == 0);
      lv = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, lim));
      e  = ($urandom_range(0, 4) != 0);
      o  = ($urandom_range(0, 9) != 0);
      step(e, l, lv, u, lim, ps, o);
      if (i % 600 == 599) async_reset();
    end
    repeat (2) @(posedge clk);
    #2;
    chk("queue_drained", 16'(q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
